// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp scheduler: default sizes, the scan FSM
// state type and the perceptual gamma mapping used on the level outputs.
package pwm_pkg;

   localparam int LEVEL_W = 8;
   localparam int NUM_CH  = 7;
   localparam int STEP_W  = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // (level*level + max) >> LEVEL_W: keeps 0, 1 and full scale fixed and is monotonic.
   function automatic logic [LEVEL_W-1:0] gamma(input logic [LEVEL_W-1:0] level);
      logic [2*LEVEL_W-1:0] sq;
      sq = ({{LEVEL_W{1'b0}}, level} * {{LEVEL_W{1'b0}}, level})
           + (2*LEVEL_W)'((1 << LEVEL_W) - 1);
      return sq[2*LEVEL_W-1:LEVEL_W];
   endfunction

endpackage

// File: rtl/pwm_ramp_step.sv
// Combinational saturating step unit. Moves one level toward its target by at
// most 'step', never overshooting and never wrapping below zero or above full
// scale. 'reached' flags the update that lands on the target.
module pwm_ramp_step
   import pwm_pkg::*;
#(
   parameter int LEVEL_W = pwm_pkg::LEVEL_W
) (
   input  logic [LEVEL_W-1:0] level,
   input  logic [LEVEL_W-1:0] target,
   input  logic [STEP_W-1:0]  step,
   output logic [LEVEL_W-1:0] level_next,
   output logic               reached
);

   logic [LEVEL_W:0] step_ext;
   logic [LEVEL_W:0] sum;
   logic [LEVEL_W:0] diff;

   // One extra bit of headroom so level+step cannot wrap before clamping.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      level_next = level;
      step_ext   = (LEVEL_W+1)'(step);
      sum        = {1'b0, level} + step_ext;
      diff       = {1'b0, level} - {1'b0, target};
      if (level < target) begin
         if (sum > {1'b0, target}) begin
            level_next = target;
         end else begin
            level_next = sum[LEVEL_W-1:0];
         end
      end else if (level > target) begin
         // diff is only meaningful here, where level > target.
         if (diff <= step_ext) begin
            level_next = target;
         end else begin
            level_next = level - LEVEL_W'(step);
         end
      end
      reached = (level != target) && (level_next == target);
   end

endmodule

// File: rtl/pwm_ramp_scheduler.sv
// Per-channel fade/ramp controller. Holds the duty level, target and step of
// every channel and, on each ramp tick, scans the channels round-robin through
// one shared step unit. Configuration is accepted only between scans.
// Optional build macro PWM_RAMP_GAMMA_EN: gamma-corrected level_out.
module pwm_ramp_scheduler
   import pwm_pkg::*;
#(
   parameter int NUM_CH   = pwm_pkg::NUM_CH,
   parameter int LEVEL_W  = pwm_pkg::LEVEL_W,
   parameter int TICK_DIV = 16
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cfg_valid,
   output logic                      cfg_ready,
   input  logic [2:0]                cfg_ch,
   input  logic [LEVEL_W-1:0]        cfg_target,
   input  logic [STEP_W-1:0]         cfg_step,
   output logic [NUM_CH*LEVEL_W-1:0] level_out,
   output logic [NUM_CH-1:0]         busy,
   output logic [NUM_CH-1:0]         done
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int PTR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   generate
      if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
         $error("pwm_ramp_scheduler: NUM_CH must be 1..8");
      end
      if (TICK_DIV < NUM_CH + 2) begin : g_bad_tick_div
         $error("pwm_ramp_scheduler: TICK_DIV must be at least NUM_CH+2");
      end
   endgenerate

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt;
   logic                tick_pending;
   logic [PTR_W-1:0]    ptr;
   logic [LEVEL_W-1:0]  level_q  [NUM_CH];
   logic [LEVEL_W-1:0]  target_q [NUM_CH];
   logic [STEP_W-1:0]   step_q   [NUM_CH];
   logic [NUM_CH-1:0]   done_q;

   logic                tick_wrap;
   logic                tick_take;
   logic                scan_en;
   logic                scan_last;
   logic                cfg_accept;
   logic [LEVEL_W-1:0]  cur_level;
   logic [LEVEL_W-1:0]  cur_target;
   logic [STEP_W-1:0]   cur_step;
   logic [LEVEL_W-1:0]  step_next;
   logic                step_reached;

   assign tick_wrap  = (tick_cnt == TICK_W'(TICK_DIV - 1));
   assign scan_last  = (ptr == PTR_W'(NUM_CH - 1));
   assign cfg_accept = cfg_valid && cfg_ready;

   // Free-running tick divider; a wrap not yet consumed by the FSM is remembered.
   always_ff @(posedge clk) begin
      // NOTE: registers are written with <= so every flop samples pre-edge values.
      if (reset) begin
         tick_cnt     <= '0;
         tick_pending <= 1'b0;
      end else begin
         tick_cnt <= tick_wrap ? '0 : tick_cnt + 1'b1;
         if (tick_take) begin
            tick_pending <= 1'b0;
         end else if (tick_wrap) begin
            tick_pending <= 1'b1;
         end
      end
   end

   // FSM state register and scan pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         ptr     <= '0;
      end else begin
         state_q <= state_d;
         if (tick_take) begin
            ptr <= '0;
         end else if (scan_en) begin
            ptr <= scan_last ? '0 : ptr + 1'b1;
         end
      end
   end

   // Next state and control: a tick seen in IDLE (pending or wrapping now) starts a scan.
   always_comb begin
      state_d   = state_q;
      cfg_ready = 1'b0;
      scan_en   = 1'b0;
      tick_take = 1'b0;
      case (state_q)
         IDLE: begin
            cfg_ready = 1'b1;
            if (tick_pending || tick_wrap) begin
               tick_take = 1'b1;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            scan_en = 1'b1;
            if (scan_last) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Select the channel under the scan pointer for the shared step unit.
   always_comb begin
      cur_level  = '0;
      cur_target = '0;
      cur_step   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ptr == PTR_W'(i)) begin
            cur_level  = level_q[i];
            cur_target = target_q[i];
            cur_step   = step_q[i];
         end
      end
   end

   pwm_ramp_step #(
      .LEVEL_W    (LEVEL_W)
   ) u_step (
      .level      (cur_level),
      .target     (cur_target),
      .step       (cur_step),
      .level_next (step_next),
      .reached    (step_reached)
   );

   // Channel state: scan updates and config writes never coincide (cfg_ready is low in SCAN).
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the per-channel arrays are reset because levels must start at zero.
         for (int i = 0; i < NUM_CH; i++) begin
            level_q[i]  <= '0;
            target_q[i] <= '0;
            step_q[i]   <= '0;
         end
         done_q <= '0;
      end else begin
         done_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            if (scan_en && ptr == PTR_W'(i)) begin
               level_q[i] <= step_next;
               done_q[i]  <= step_reached;
            end
            if (cfg_accept && cfg_ch == 3'(i)) begin
               target_q[i] <= cfg_target;
               step_q[i]   <= cfg_step;
               if (cfg_step == '0) begin
                  level_q[i] <= cfg_target;
                  done_q[i]  <= (level_q[i] != cfg_target);
               end
            end
         end
      end
   end

   // Outputs straight from registers: busy flags and the (optionally gamma-mapped) levels.
   always_comb begin
      level_out = '0;
      busy      = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         busy[i] = (level_q[i] != target_q[i]);
`ifdef PWM_RAMP_GAMMA_EN
         level_out[i*LEVEL_W +: LEVEL_W] = gamma(level_q[i]);
`else
         level_out[i*LEVEL_W +: LEVEL_W] = level_q[i];
`endif
      end
   end

   assign done = done_q;

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Self-checking bench for pwm_ramp_scheduler. Expected done pulses are queued
// before stimulus and popped by a monitor when the DUT pulses done; level
// expectations come from a per-channel table kept by the bench.
module tb_pwm_ramp_scheduler;

   localparam int NUM_CH   = 7;
   localparam int LEVEL_W  = 8;
   localparam int TICK_DIV = 16;
   localparam int TIMEOUT  = 64;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      cfg_valid;
   logic                      cfg_ready;
   logic [2:0]                cfg_ch;
   logic [LEVEL_W-1:0]        cfg_target;
   logic [3:0]                cfg_step;
   logic [NUM_CH*LEVEL_W-1:0] level_out;
   logic [NUM_CH-1:0]         busy;
   logic [NUM_CH-1:0]         done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int ch;
      int lvl;
   } done_t;

   done_t exp_q[$];
   int    exp_lvl[NUM_CH];

   pwm_ramp_scheduler #(
      .NUM_CH     (NUM_CH),
      .LEVEL_W    (LEVEL_W),
      .TICK_DIV   (TICK_DIV)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_ch     (cfg_ch),
      .cfg_target (cfg_target),
      .cfg_step   (cfg_step),
      .level_out  (level_out),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_out(input int l);
`ifdef PWM_RAMP_GAMMA_EN
      return 8'((l * l + 255) / 256);
`else
      return 8'(l);
`endif
   endfunction

   function automatic logic [NUM_CH*LEVEL_W-1:0] exp_bus();
      logic [NUM_CH*LEVEL_W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_CH; i++) r[i*LEVEL_W +: LEVEL_W] = exp_out(exp_lvl[i]);
      return r;
   endfunction

   function automatic logic [7:0] ch_out(input int ch);
      return level_out[ch*LEVEL_W +: LEVEL_W];
   endfunction

   task automatic push_done(input int ch, input int lvl);
      done_t e;
      e.ch  = ch;
      e.lvl = lvl;
      exp_q.push_back(e);
   endtask

   // Scoreboard side: every done bit must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         for (int b = 0; b < NUM_CH; b++) begin
            if (done[b] === 1'b1) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL done_unexpected: done[%0d] pulsed, no pulse expected", b);
               end else begin
                  done_t e;
                  e = exp_q.pop_front();
                  if (e.ch != b || ch_out(b) !== exp_out(e.lvl)) begin
                     errors++;
                     $display("FAIL done_event: got ch %0d level_out %0d, expected ch %0d level_out %0d",
                              b, ch_out(b), e.ch, exp_out(e.lvl));
                  end
               end
            end
         end
      end
   end

   task automatic cfg_write(input logic [2:0] ch, input logic [7:0] tgt, input logic [3:0] stp);
      int n;
      @(negedge clk);
      cfg_valid  = 1'b1;
      cfg_ch     = ch;
      cfg_target = tgt;
      cfg_step   = stp;
      n = 0;
      while (cfg_ready !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= TIMEOUT) begin
         errors++;
         $display("FAIL cfg_accept_timeout: waited %0d cycles, limit %0d", n, TIMEOUT);
      end
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
   endtask

   task automatic wait_scan();
      int n;
      int low;
      n = 0;
      while (cfg_ready === 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      low = 0;
      while (cfg_ready !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
         low++;
      end
      checks++;
      if (n >= TIMEOUT) begin
         errors++;
         $display("FAIL scan_timeout: waited %0d cycles, limit %0d", n, TIMEOUT);
      end
      checks++;
      if (low != NUM_CH) begin
         errors++;
         $display("FAIL scan_length: cfg_ready low %0d cycles, expected %0d", low, NUM_CH);
      end
   endtask

   task automatic check_ch(input string name, input int ch, input int lvl);
      checks++;
      if (ch_out(ch) !== exp_out(lvl)) begin
         errors++;
         $display("FAIL %s: level_out[%0d] = %0d, expected %0d", name, ch, ch_out(ch), exp_out(lvl));
      end
   endtask

   task automatic test_reset();
      bit prev;
      int low;
      int last_start;
      reset      = 1'b1;
      cfg_valid  = 1'b0;
      cfg_ch     = '0;
      cfg_target = '0;
      cfg_step   = '0;
      for (int i = 0; i < NUM_CH; i++) exp_lvl[i] = 0;
      repeat (3) @(negedge clk);
      checks++;
      if (level_out !== '0 || busy !== '0 || done !== '0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_state: level_out %h busy %b done %b ready %b, expected 0 0 0 1",
                  level_out, busy, done, cfg_ready);
      end
      reset      = 1'b0;
      prev       = 1'b1;
      low        = 0;
      last_start = -1;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk);
         checks++;
         if (level_out !== '0 || busy !== '0) begin
            errors++;
            $display("FAIL idle_outputs: level_out %h busy %b, expected all zero", level_out, busy);
         end
         if (cfg_ready === 1'b0) begin
            if (prev) begin
               if (last_start >= 0) begin
                  checks++;
                  if (c - last_start != TICK_DIV) begin
                     errors++;
                     $display("FAIL scan_period: %0d cycles between scans, expected %0d",
                              c - last_start, TICK_DIV);
                  end
               end
               last_start = c;
            end
            low++;
         end else begin
            if (!prev) begin
               checks++;
               if (low != NUM_CH) begin
                  errors++;
                  $display("FAIL idle_scan_length: ready low %0d cycles, expected %0d", low, NUM_CH);
               end
            end
            low = 0;
         end
         prev = (cfg_ready === 1'b1);
      end
      checks++;
      if (last_start < 0) begin
         errors++;
         $display("FAIL scan_seen: no scan in 100 cycles, expected about 6");
      end
   endtask

   task automatic test_immediate();
      push_done(2, 100);
      cfg_write(3'd2, 8'd100, 4'd0);
      exp_lvl[2] = 100;
      checks++;
      if (level_out !== exp_bus() || busy !== '0) begin
         errors++;
         $display("FAIL immediate_level: level_out %h busy %b, expected %h 0", level_out, busy, exp_bus());
      end
      repeat (20) @(negedge clk);
      check_ch("immediate_hold", 2, 100);
   endtask

   task automatic test_ramp();
      cfg_write(3'd0, 8'd10, 4'd4);
      check_ch("ramp_no_jump", 0, 0);
      checks++;
      if (busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL ramp_busy: busy[0] = %b, expected 1", busy[0]);
      end
      wait_scan();
      check_ch("ramp_tick1", 0, 4);
      wait_scan();
      check_ch("ramp_tick2", 0, 8);
      push_done(0, 10);
      wait_scan();
      exp_lvl[0] = 10;
      check_ch("ramp_tick3", 0, 10);
      checks++;
      if (busy !== '0) begin
         errors++;
         $display("FAIL ramp_busy_drop: busy %b, expected 0", busy);
      end
      check_ch("ramp_other_ch", 2, 100);
   endtask

   task automatic test_retarget();
      push_done(5, 200);
      cfg_write(3'd5, 8'd200, 4'd0);
      check_ch("retarget_start", 5, 200);
      push_done(5, 195);
      cfg_write(3'd5, 8'd195, 4'd15);
      wait_scan();
      exp_lvl[5] = 195;
      check_ch("retarget_clamp", 5, 195);
      wait_scan();
      check_ch("retarget_settled", 5, 195);
      // Mid-ramp retarget continues from the current level.
      cfg_write(3'd3, 8'd100, 4'd15);
      wait_scan();
      check_ch("midramp_up", 3, 15);
      cfg_write(3'd3, 8'd5, 4'd4);
      wait_scan();
      check_ch("midramp_down1", 3, 11);
      wait_scan();
      check_ch("midramp_down2", 3, 7);
      push_done(3, 5);
      wait_scan();
      exp_lvl[3] = 5;
      check_ch("midramp_final", 3, 5);
   endtask

   task automatic test_saturate();
      push_done(6, 250);
      cfg_write(3'd6, 8'd250, 4'd0);
      push_done(6, 255);
      cfg_write(3'd6, 8'd255, 4'd15);
      wait_scan();
      exp_lvl[6] = 255;
      check_ch("saturate_top", 6, 255);
      push_done(4, 10);
      cfg_write(3'd4, 8'd10, 4'd0);
      push_done(4, 0);
      cfg_write(3'd4, 8'd0, 4'd15);
      wait_scan();
      exp_lvl[4] = 0;
      check_ch("saturate_bottom", 4, 0);
   endtask

   task automatic test_discard();
      int n;
      n = 0;
      while (cfg_ready === 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      cfg_valid  = 1'b1;
      cfg_ch     = 3'd7;
      cfg_target = 8'hAA;
      cfg_step   = 4'd0;
      n = 0;
      while (cfg_ready !== 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n < 1 || n > NUM_CH) begin
         errors++;
         $display("FAIL discard_stall: stalled %0d cycles, expected 1..%0d", n, NUM_CH);
      end
      @(posedge clk);
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (3) begin
         checks++;
         if (level_out !== exp_bus() || busy !== '0) begin
            errors++;
            $display("FAIL discard_outputs: level_out %h busy %b, expected %h 0", level_out, busy, exp_bus());
         end
         @(negedge clk);
      end
   endtask

   task automatic test_gamma();
      push_done(1, 128);
      cfg_write(3'd1, 8'd128, 4'd0);
      exp_lvl[1] = 128;
      check_ch("gamma_mid", 1, 128);
      push_done(1, 255);
      cfg_write(3'd1, 8'd255, 4'd0);
      exp_lvl[1] = 255;
      check_ch("gamma_full", 1, 255);
   endtask

   task automatic test_reset_midscan();
      int n;
      cfg_write(3'd0, 8'd200, 4'd15);
      n = 0;
      while (cfg_ready === 1'b1 && n < TIMEOUT) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) exp_lvl[i] = 0;
      checks++;
      if (level_out !== '0 || busy !== '0 || done !== '0 || cfg_ready !== 1'b1) begin
         errors++;
         $display("FAIL midscan_reset: level_out %h busy %b done %b ready %b, expected 0 0 0 1",
                  level_out, busy, done, cfg_ready);
      end
      reset = 1'b0;
      wait_scan();
      checks++;
      if (level_out !== '0 || busy !== '0) begin
         errors++;
         $display("FAIL post_reset_scan: level_out %h busy %b, expected 0 0", level_out, busy);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_immediate();
      test_ramp();
      test_retarget();
      test_saturate();
      test_discard();
      test_gamma();
      test_reset_midscan();
      repeat (4) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL done_missing: %0d expected done pulses never seen, expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pwm_ramp_scheduler.md
# pwm_ramp_scheduler

Per-channel fade/ramp controller that owns the seven 8-bit PWM duty levels and moves each one toward a programmed target at a programmed rate. It sits between the SPI register front end and the PWM comparators. A single shared step unit serves all channels, time-multiplexed by a round-robin scan that starts on each ramp tick. Configuration arrives on a valid/ready port, so the SPI logic can stall while a scan is in progress.

## Interface
- `NUM_CH`, default 7: number of PWM channels; must be 1..8.
- `LEVEL_W`, default 8: duty level width.
- `TICK_DIV`, default 16: clk cycles per ramp tick; must be ≥ `NUM_CH`+2 (elaboration-time check).
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset`  in  1: synchronous, active-high.
- `cfg_valid`  in  1: configuration write request.
- `cfg_ready`  out  1: write accepted when `cfg_valid && cfg_ready`.
- `cfg_ch`  in  3: target channel.
- `cfg_target`  in  `LEVEL_W`: destination level.
- `cfg_step`  in  4: increment per tick; 0 means jump immediately.
- `level_out`  out  `NUM_CH*LEVEL_W`: channel n occupies bits [n*8+7:n*8]; feeds the PWM compare.
- `busy`  out  `NUM_CH`: bit n is high while level[n] != target[n].
- `done`  out  `NUM_CH`: one-cycle pulse when channel n reaches its target during a scan.

## Operation
- Reset: tick counter, scan pointer, all levels, targets, and steps become 0. State becomes IDLE. `cfg_ready`=1, `busy`=0, `done`=0, `level_out`=0.
- Tick counter runs 0..`TICK_DIV`-1 and wraps. On wrap it sets `tick_pending`.
- FSM states:
  - IDLE: `cfg_ready`=1. If `tick_pending`, clear it and go to SCAN with pointer=0.
  - SCAN: `cfg_ready`=0. Each cycle the step unit updates the channel at the pointer, then the pointer increments. After channel `NUM_CH`-1 the FSM returns to IDLE.
- Step unit (9-bit arithmetic):
  - If level<target: level = min(level+step, target).
  - If level>target: level = max(level−step, target), computed without underflow.
  - If equal: no change.
  - If the update makes level equal to target and it was not equal before, `done[n]` pulses in the next cycle.
- Config accept in IDLE:
  - target[ch] and step[ch] are written.
  - If `cfg_step`=0, level[ch] is set to `cfg_target` in the same edge and `done[ch]` pulses next cycle if the value changed.
  - `cfg_ch` ≥ `NUM_CH` is accepted and discarded.
- Re-programming a channel mid-ramp retargets from its current level; the level never jumps.
- A `cfg_step` of 0 stored for a channel with level != target cannot occur: immediate mode always equalises.

## Timing
- Config to visible level: immediate mode, 1 cycle after the accept edge. Ramp mode, first change at the next scan.
- Scan occupies `NUM_CH` cycles. `cfg_ready` is low for exactly those cycles.
- Tick wrap to channel 0 update: 1 cycle. Channel n updates n cycles later.
- Simultaneous tick wrap and config accept: the config takes effect, then the scan starts next cycle and uses the new values.
- `reset` asserted mid-scan: everything returns to reset values on that edge, and no `done` pulse is generated.
- `busy` and `level_out` are combinational from registers only.

## Configuration
- Macro: `PWM_RAMP_GAMMA_EN`.
- Defined: `level_out` per channel = (level*level + 255) >> 8. This is perceptual correction that maps 0→0, 1→1, 255→255 and is monotonic. Internal level, `busy`, and `done` are unaffected.
- Undefined: `level_out` = level directly.

## Structure
- Package `pwm_pkg` holds:
  - `LEVEL_W`, `NUM_CH`, and `STEP_W`=4 constants;
  - the state enum {IDLE, SCAN};
  - the gamma function, shared with any future readback path.
- Sub-module `pwm_ramp_step` is the combinational saturating step unit:
  - inputs: level, target, step;
  - outputs: next level, reached flag.
- It is instantiated once and shared by the scan.

## Test plan
- Reset, then no config for 100 cycles → all `level_out`=0, `busy`=0, `done` never pulses, `cfg_ready` low only during the 7-cycle scans every 16 cycles.
- Ch2 target 100, step 0 → `level_out[2]`=100 one cycle after accept; `done[2]` pulses once; other channels stay 0.
- Ch0 target 10, step 4 → level 4, 8, 10 on three successive ticks; `done[0]` pulses at the third; `busy[0]` then drops.
- Ch5 at 200, retarget to 195 with step 15 → next tick yields 195, not 185; `done[5]` pulses once.
- Hold `cfg_valid` with ch=7 during a scan → accept is stalled until IDLE, then the write is discarded and no outputs change.
- With `PWM_RAMP_GAMMA_EN`, ch1 set to 128 with step 0 → `level_out[1]`=64; set to 255 → 255.
